// File: rtl/fir_pkg.sv
// Shared address map and ap_ctrl bit layout for the FIR configuration block.
package fir_pkg;

  localparam logic [31:0] ADDR_AP_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_DATA_LEN = 32'h0000_0010;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h0000_0020;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  // True when a (zero-extended) byte address falls on a word inside the tap window.
  function automatic logic is_tap_addr(input logic [31:0] addr, input int unsigned num_taps);
    logic [31:0] tap_end;
    tap_end = ADDR_TAP_BASE + (32'(num_taps) * 32'd4);
    return (addr >= ADDR_TAP_BASE) && (addr < tap_end) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/axil_rd_fsm.sv
// AXI-Lite read channel: address latch, one wait cycle for the tap BRAM, then a held response.
module axil_rd_fsm #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   ar_block,
  input  logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rd_value,
  output logic                   arready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [pADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_capture,
  output logic                   ar_fire
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  rd_state_t              state_reg, state_next;
  logic [pADDR_WIDTH-1:0] rd_addr_reg;
  logic [pDATA_WIDTH-1:0] rdata_reg;

  // State register; reset drops any in-flight read without responding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= R_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: fixed two-cycle path from address accept to response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      R_IDLE:  if (ar_fire) state_next = R_ADDR;
      R_ADDR:  state_next = R_DATA;
      R_DATA:  if (rready) state_next = R_IDLE;
      default: state_next = R_IDLE;
    endcase
  end

  // Outputs: arready only in idle and when the BRAM is not claimed by a write.
  always_comb begin
    arready    = (state_reg == R_IDLE) && arvalid && !ar_block;
    ar_fire    = arready;
    rvalid     = (state_reg == R_DATA);
    rd_capture = (state_reg == R_ADDR);
  end

  // Latch the address on accept and the response word at the end of the BRAM wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      if (ar_fire)    rd_addr_reg <= araddr;
      if (rd_capture) rdata_reg   <= rd_value;
    end
  end

  assign rd_addr = rd_addr_reg;
  assign rdata   = rdata_reg;

endmodule

// File: rtl/fir_axil_cfg.sv
// AXI-Lite slave for the FIR engine: ap_ctrl, data_length and tap BRAM arbitration.
module fir_axil_cfg
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] core_tap_A,
  output logic                   ap_start_o,
  input  logic                   core_done,
  output logic [31:0]            data_length
);

  logic                   ap_start_reg, ap_done_reg, ap_idle_reg;
  logic [31:0]            data_length_reg;
  logic                   wr_gap_reg;
  logic                   rd_bram_reg;
  logic                   busy, wr_fire, wr_is_tap, wr_bram;
  logic                   rd_is_tap, rd_bram, ar_block, ar_fire, rd_capture, ctrl_rd;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic [pDATA_WIDTH-1:0] rd_value;

  assign busy      = !ap_idle_reg;
  // Writes need both channels; the gap register forces a low-ready cycle after each accept.
  assign wr_fire   = awvalid && wvalid && !wr_gap_reg;
  assign awready   = wr_fire;
  assign wready    = wr_fire;
  assign wr_is_tap = is_tap_addr(32'(awaddr), Tape_Num);
  assign wr_bram   = wr_fire && wr_is_tap && !busy;
  assign rd_is_tap = is_tap_addr(32'(araddr), Tape_Num);
  // A tap read loses the BRAM to a same-cycle tap write and retries next cycle.
  assign ar_block  = wr_bram && rd_is_tap;
  assign rd_bram   = ar_fire && rd_is_tap && !busy;
  assign ctrl_rd   = rd_capture && (rd_addr == ADDR_AP_CTRL[pADDR_WIDTH-1:0]);

  axil_rd_fsm #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_rd (
    .clk       (axis_clk),
    .rst_n     (axis_rst_n),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .ar_block  (ar_block),
    .rready    (rready),
    .rd_value  (rd_value),
    .arready   (arready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rd_addr   (rd_addr),
    .rd_capture(rd_capture),
    .ar_fire   (ar_fire)
  );

  // Tap BRAM port mux: engine while busy, otherwise host write, then host read.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (busy) begin
      tap_EN = 1'b1;
      tap_A  = core_tap_A;
    end else if (wr_bram) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - ADDR_TAP_BASE[pADDR_WIDTH-1:0];
      tap_Di = wdata;
    end else if (rd_bram) begin
      tap_EN = 1'b1;
      tap_A  = araddr - ADDR_TAP_BASE[pADDR_WIDTH-1:0];
    end
  end

  // Read data select; core_done is folded in so a coincident status read sees completion.
  always_comb begin
    rd_value = '0;
    if (rd_bram_reg) begin
      rd_value = tap_Do;
    end else if (rd_addr == ADDR_AP_CTRL[pADDR_WIDTH-1:0]) begin
      rd_value[AP_START] = ap_start_reg;
      rd_value[AP_DONE]  = ap_done_reg || core_done;
      rd_value[AP_IDLE]  = ap_idle_reg || core_done;
    end else if (rd_addr == ADDR_DATA_LEN[pADDR_WIDTH-1:0]) begin
      rd_value = pDATA_WIDTH'(data_length_reg);
    end
  end

  // ap_ctrl status, data_length and write-gap bookkeeping.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_start_reg    <= 1'b0;
      ap_done_reg     <= 1'b0;
      ap_idle_reg     <= 1'b1;
      data_length_reg <= '0;
      wr_gap_reg      <= 1'b0;
      rd_bram_reg     <= 1'b0;
    end else begin
      wr_gap_reg   <= wr_fire;
      ap_start_reg <= 1'b0;
      if (ar_fire) rd_bram_reg <= rd_bram;
      if (wr_fire && (awaddr == ADDR_AP_CTRL[pADDR_WIDTH-1:0]) && wdata[AP_START] && ap_idle_reg) begin
        ap_start_reg <= 1'b1;
        ap_idle_reg  <= 1'b0;
        ap_done_reg  <= 1'b0;
      end
      if (wr_fire && (awaddr == ADDR_DATA_LEN[pADDR_WIDTH-1:0]) && !busy)
        data_length_reg <= 32'(wdata);
      if (ctrl_rd && !core_done) ap_done_reg <= 1'b0;
      if (core_done) begin
        ap_done_reg <= 1'b1;
        ap_idle_reg <= 1'b1;
      end
    end
  end

  assign ap_start_o  = ap_start_reg;
  assign data_length = data_length_reg;

endmodule
